muldiv_hilo_unit: RTL and testbench

Multi-cycle multiply/divide sequencer that owns the architectural HI/LO registers for MULT, MULTU, DIV, DIVU, MTHI and MTLO. It sits beside the combinational ALU. The ALU keeps the single-cycle operations, and this block runs 32-iteration shift-add and restoring-divide sequences. It asserts `stall` so the CPU holds MFHI/MFLO and any further mul/div until the result is final.

---
 rtl/muldiv_pkg.sv | 33 +++
 rtl/muldiv_hilo_unit.sv | 167 ++++++++++++++++
 tb/tb_muldiv_hilo_unit.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit, the ALU and the decoder:
// R-type funct codes and the sequencer state encoding.
package muldiv_pkg;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    MD_IDLE  = 2'd0,
    MD_MUL   = 2'd1,
    MD_DIV   = 2'd2,
    MD_FIXUP = 2'd3
  } md_state_t;

  function automatic logic is_mul_op(input logic [5:0] f);
    return (f == F_MULT) || (f == F_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [5:0] f);
    return (f == F_DIV) || (f == F_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [5:0] f);
    return (f == F_MULT) || (f == F_DIV);
  endfunction

endpackage

// File: rtl/muldiv_hilo_unit.sv
// Multi-cycle HI/LO sequencer: WIDTH-step shift-add multiply and restoring divide
// on unsigned magnitudes, with sign fixup applied in a final cycle.
module muldiv_hilo_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  md_state_t          r_state;
  md_state_t          w_next_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;      // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   r_opnd;     // multiplicand or divisor magnitude
  logic               r_is_mul;
  logic               r_neg_lo;   // product sign, or quotient sign
  logic               r_neg_hi;   // remainder sign (dividend sign)
  logic               r_wr_en;    // cleared on divide-by-zero
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_accept;
  logic               w_last;
  logic               w_rs_neg;
  logic               w_rt_neg;
  logic [WIDTH-1:0]   w_rs_mag;
  logic [WIDTH-1:0]   w_rt_mag;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_step;
  logic [WIDTH:0]     w_div_trial;
  logic [2*WIDTH-1:0] w_div_step;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_accept = (r_state == MD_IDLE) && start;
  assign w_last   = (r_cnt == LAST_STEP);

  assign w_rs_neg = is_signed_op(funct) && rs_data[WIDTH-1];
  assign w_rt_neg = is_signed_op(funct) && rt_data[WIDTH-1];
  assign w_rs_mag = w_rs_neg ? (~rs_data + 1'b1) : rs_data;
  assign w_rt_mag = w_rt_neg ? (~rt_data + 1'b1) : rt_data;

  // Shift-add: conditionally add the multiplicand into the upper half, then shift right.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Restoring step: the trial uses the remainder already shifted left by one bit.
  assign w_div_trial = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opnd};
  assign w_div_step  = w_div_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                          : {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  assign w_prod_fix = r_neg_lo ? (~r_acc + 1'b1) : r_acc;
  assign w_quo_fix  = r_neg_lo ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
  assign w_rem_fix  = r_neg_hi ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (reset) r_state <= MD_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: default first so every path assigns the next state and no latch is inferred.
    w_next_state = r_state;
    case (r_state)
      MD_IDLE: begin
        if (start && is_mul_op(funct))      w_next_state = MD_MUL;
        else if (start && is_div_op(funct)) w_next_state = (rt_data == '0) ? MD_FIXUP : MD_DIV;
      end
      MD_MUL:   if (w_last) w_next_state = MD_FIXUP;
      MD_DIV:   if (w_last) w_next_state = MD_FIXUP;
      MD_FIXUP: w_next_state = MD_IDLE;
      default:  w_next_state = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_is_mul <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_wr_en  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      // NOTE: non-blocking throughout so every register samples pre-edge values.
      r_done <= 1'b0;
      case (r_state)
        MD_IDLE: begin
          if (w_accept) begin
            if (funct == F_MTHI) r_hi <= rs_data;
            if (funct == F_MTLO) r_lo <= rs_data;
            if (is_mul_op(funct)) begin
              r_acc    <= {{WIDTH{1'b0}}, w_rt_mag};
              r_opnd   <= w_rs_mag;
              r_is_mul <= 1'b1;
              r_neg_lo <= w_rs_neg ^ w_rt_neg;
              r_neg_hi <= 1'b0;
              r_wr_en  <= 1'b1;
              r_cnt    <= '0;
              r_busy   <= 1'b1;
            end else if (is_div_op(funct)) begin
              r_acc    <= {{WIDTH{1'b0}}, w_rs_mag};
              r_opnd   <= w_rt_mag;
              r_is_mul <= 1'b0;
              r_neg_lo <= w_rs_neg ^ w_rt_neg;
              r_neg_hi <= w_rs_neg;
              r_wr_en  <= (rt_data != '0);
              r_cnt    <= '0;
              r_busy   <= 1'b1;
            end
          end
        end
        MD_MUL: begin
          r_acc <= w_mul_step;
          r_cnt <= r_cnt + 1'b1;
        end
        MD_DIV: begin
          r_acc <= w_div_step;
          r_cnt <= r_cnt + 1'b1;
        end
        MD_FIXUP: begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          if (r_wr_en) begin
            if (r_is_mul) begin
              r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
              r_lo <= w_prod_fix[WIDTH-1:0];
            end else begin
              r_hi <= w_rem_fix;
              r_lo <= w_quo_fix;
            end
          end
        end
        default: r_busy <= 1'b0;
      endcase
    end
  end

  assign busy  = r_busy;
  assign stall = r_busy;
  assign done  = r_done;
  assign hi    = r_hi;
  assign lo    = r_lo;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Directed plus random checks of the HI/LO sequencer against a plain-arithmetic
// reference of MULT/MULTU/DIV/DIVU/MTHI/MTLO results and cycle timing.
module tb_muldiv_hilo_unit;

  localparam logic [5:0] C_MTHI  = 6'b010001;
  localparam logic [5:0] C_MTLO  = 6'b010011;
  localparam logic [5:0] C_MULT  = 6'b011000;
  localparam logic [5:0] C_MULTU = 6'b011001;
  localparam logic [5:0] C_DIV   = 6'b011010;
  localparam logic [5:0] C_DIVU  = 6'b011011;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  funct = '0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        busy, stall, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  muldiv_hilo_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .funct(funct),
    .rs_data(rs_data), .rt_data(rt_data),
    .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: architectural result of each instruction computed with 64-bit arithmetic.
  task automatic model_apply(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, sq, sr;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      C_MULT: begin
        p = 64'(sa * sb);
        model_hi = p[63:32]; model_lo = p[31:0];
      end
      C_MULTU: begin
        p = 64'(a) * 64'(b);
        model_hi = p[63:32]; model_lo = p[31:0];
      end
      C_DIV: if (b != 0) begin
        sq = sa / sb; sr = sa % sb;
        model_lo = 32'(sq); model_hi = 32'(sr);
      end
      C_DIVU: if (b != 0) begin
        model_lo = a / b; model_hi = a % b;
      end
      C_MTHI: model_hi = a;
      C_MTLO: model_lo = a;
      default: ;
    endcase
  endtask

  // Called with inputs driven 1 time unit after a rising edge; the next edge is E0.
  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input int inject_at);
    logic [31:0] hold_hi, hold_lo;
    int lat, exp_lat;
    bit hold_ok;
    hold_hi = hi; hold_lo = lo;
    start = 1'b1; funct = f; rs_data = a; rt_data = b;
    @(posedge clk); #1;
    start = 1'b0;
    model_apply(f, a, b);
    if (f == C_MTHI || f == C_MTLO) begin
      check({tag, " hi"}, hi, model_hi);
      check({tag, " lo"}, lo, model_lo);
      check({tag, " busy"}, {31'd0, busy}, 32'd0);
      check({tag, " done"}, {31'd0, done}, 32'd0);
      return;
    end
    check({tag, " busy@E0"}, {31'd0, busy}, 32'd1);
    check({tag, " stall@E0"}, {31'd0, stall}, 32'd1);
    lat = 0; hold_ok = 1'b1;
    while (!done && lat < 40) begin
      if (inject_at > 0 && lat == inject_at) begin
        start = 1'b1; funct = C_DIVU; rs_data = 32'd99; rt_data = 32'd5;
      end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
      if (!done && (hi !== hold_hi || lo !== hold_lo || busy !== 1'b1)) hold_ok = 1'b0;
    end
    exp_lat = ((f == C_DIV || f == C_DIVU) && b == 0) ? 1 : 33;
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " hold"}, {31'd0, hold_ok}, 32'd1);
    check({tag, " hi"}, hi, model_hi);
    check({tag, " lo"}, lo, model_lo);
    check({tag, " busy@done"}, {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check({tag, " done pulse"}, {31'd0, done}, 32'd0);
    check({tag, " idle after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin : stim
    logic [5:0] ops [6];
    logic [31:0] ra, rb;
    bit quiet_ok;
    ops[0] = C_MULT; ops[1] = C_MULTU; ops[2] = C_DIV;
    ops[3] = C_DIVU; ops[4] = C_MTHI;  ops[5] = C_MTLO;

    repeat (2) @(posedge clk);
    #1;
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset stall", {31'd0, stall}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op("multu_max", C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check("multu_max hi const", hi, 32'hFFFF_FFFE);
    check("multu_max lo const", lo, 32'h0000_0001);
    run_op("mult_neg3x7", C_MULT, 32'hFFFF_FFFD, 32'd7, 0);
    run_op("mult_min_sq", C_MULT, 32'h8000_0000, 32'h8000_0000, 0);
    check("mult_min_sq hi const", hi, 32'h4000_0000);
    run_op("div_neg7by2", C_DIV, 32'hFFFF_FFF9, 32'd2, 0);
    check("div_neg7by2 lo const", lo, 32'hFFFF_FFFD);
    run_op("divu_100by7", C_DIVU, 32'd100, 32'd7, 0);
    run_op("div_min_by_m1", C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("div_min_by_m1 lo const", lo, 32'h8000_0000);
    run_op("mthi", C_MTHI, 32'h1234_5678, 32'd0, 0);
    run_op("mtlo_zero", C_MTLO, 32'd0, 32'd0, 0);
    run_op("divu_by_zero", C_DIVU, 32'd5, 32'd0, 0);
    check("divu_by_zero hi const", hi, 32'h1234_5678);
    run_op("div_neg_by_zero", C_DIV, 32'h8000_0000, 32'd0, 0);

    for (int i = 0; i < 12; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 20));
        2:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 4) == 0) ra = 32'h8000_0000;
      run_op($sformatf("rand%0d", i), ops[$urandom_range(0, 5)], ra, rb, 0);
    end

    // Reset in the middle of a MULTU discards it.
    run_op("pre_reset_mthi", C_MTHI, 32'hDEAD_BEEF, 32'd0, 0);
    start = 1'b1; funct = C_MULTU; rs_data = 32'd1234; rt_data = 32'd5678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_hi = '0; model_lo = '0;
    check("midreset busy", {31'd0, busy}, 32'd0);
    check("midreset hi", hi, 32'd0);
    check("midreset lo", lo, 32'd0);
    check("midreset done", {31'd0, done}, 32'd0);
    quiet_ok = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) quiet_ok = 1'b0;
    end
    check("midreset quiet", {31'd0, quiet_ok}, 32'd1);
    run_op("mtlo_after_reset", C_MTLO, 32'h0000_00A5, 32'd0, 0);

    // A DIVU start during a running MULTU must be ignored.
    run_op("multu_ignore_start", C_MULTU, 32'd3, 32'd4, 4);
    check("ignore hi const", hi, 32'd0);
    check("ignore lo const", lo, 32'd12);
    quiet_ok = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) quiet_ok = 1'b0;
    end
    check("ignore single done", {31'd0, quiet_ok}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
